// File: rtl/uart_apb_arbiter_if.sv
// Requester handshake plus APB master port of uart_apb_arbiter.
// The arbiter connects through the master modport; the slave modport is the environment side.
interface uart_apb_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          req_we;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_wdata;
  logic [NREQ*DATA_W/8-1:0] req_strb;
  logic [NREQ-1:0]          ack;
  logic [DATA_W-1:0]        rdata;
  logic                     err;
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDR_W-1:0]        paddr;
  logic [DATA_W-1:0]        pwdata;
  logic [DATA_W/8-1:0]      pstrb;
  logic [DATA_W-1:0]        prdata;
  logic                     pready;
  logic                     pslverr;

  modport master (
    input  req, req_we, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    output ack, rdata, err, psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    input  ack, rdata, err, psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/uart_apb_arbiter.sv
// Round-robin arbiter that sequences one requester at a time onto the APB port
// of the UART register block, with a wait-state timeout and a one-cycle ack.
module uart_apb_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input logic                pclk,
  input logic                preset,
  uart_apb_arbiter_if.master bus
);
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  last_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic [NREQ-1:0]   ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];
  logic [STRB_W-1:0] strb_arr  [NREQ];

  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic              found;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    assign strb_arr[i]  = bus.req_strb[i*STRB_W +: STRB_W];
  end

  // Scan starts one past the last granted index and wraps at NREQ-1.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_IDX;
      wait_cnt   <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant    <= winner;
            pwrite_q <= bus.req_we[winner];
            paddr_q  <= addr_arr[winner];
            pwdata_q <= wdata_arr[winner];
            pstrb_q  <= strb_arr[winner];
            psel_q   <= 1'b1;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // wait_cnt counts the pready-low cycles already spent; pready wins on the limit cycle.
          if (bus.pready) begin
            rdata_q   <= pwrite_q ? '0 : bus.prdata;
            err_q     <= bus.pslverr;
            ack_q     <= NREQ'(1) << grant;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= DONE;
          end else if (MAX_WAIT != 0 && wait_cnt == WAIT_LIMIT) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            ack_q     <= NREQ'(1) << grant;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          ack_q      <= '0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pstrb   = pstrb_q;
endmodule
